// File: rtl/multicycle_control_if.sv
// Control-unit bundle: IR fields and memory handshakes in, datapath strobes out.
// The controller sits on the slave side and the datapath on the master side.
interface multicycle_control_if #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
);
  logic [3:0]         opcode;
  logic [5:0]         func;
  logic               i_ready;
  logic               d_ready;
  logic               i_read;
  logic               ir_write;
  logic               d_read;
  logic               d_write;
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_src;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         wb_src;
  logic               alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               open_port;
  logic               is_halted;
  logic [CNT_W-1:0]   num_inst;

  modport slave (
    input  opcode, func, i_ready, d_ready,
    output i_read, ir_write, d_read, d_write, pc_write, pc_write_cond, pc_src,
           reg_write, reg_dst, wb_src, alu_src_b, alu_op, open_port, is_halted,
           num_inst
  );

  modport master (
    output opcode, func, i_ready, d_ready,
    input  i_read, ir_write, d_read, d_write, pc_write, pc_write_cond, pc_src,
           reg_write, reg_dst, wb_src, alu_src_b, alu_op, open_port, is_halted,
           num_inst
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU controller: IF/ID/EX/MEM/WB/HALT FSM with state+opcode decoded strobes.
// Define MULTICYCLE_CTRL_NUM_INST_EN to build the retired-instruction counter num_inst.
module multicycle_control #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  multicycle_control_if.slave bus
);
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FUNC_W   = 6;

  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BGZ   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BLZ   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADI   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LHI   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(15);

  localparam logic [FUNC_W-1:0] FN_JPR = FUNC_W'(25);
  localparam logic [FUNC_W-1:0] FN_JRL = FUNC_W'(26);
  localparam logic [FUNC_W-1:0] FN_WWD = FUNC_W'(28);
  localparam logic [FUNC_W-1:0] FN_HLT = FUNC_W'(29);

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

  state_e state_q, state_d;

  logic is_r, is_r_alu, is_wwd, is_jpr, is_jrl, is_hlt;
  logic is_adi, is_ori, is_lhi, is_lwd, is_swd, is_jmp, is_jal;
  logic is_bne, is_beq, is_bgz, is_blz, is_branch;

  // Opcode/func decode; IR is stable from ID onward
  assign is_r      = bus.opcode == OP_RTYPE;
  assign is_r_alu  = is_r && (bus.func < FUNC_W'(8));
  assign is_wwd    = is_r && (bus.func == FN_WWD);
  assign is_jpr    = is_r && (bus.func == FN_JPR);
  assign is_jrl    = is_r && (bus.func == FN_JRL);
  assign is_hlt    = is_r && (bus.func == FN_HLT);
  assign is_adi    = bus.opcode == OP_ADI;
  assign is_ori    = bus.opcode == OP_ORI;
  assign is_lhi    = bus.opcode == OP_LHI;
  assign is_lwd    = bus.opcode == OP_LWD;
  assign is_swd    = bus.opcode == OP_SWD;
  assign is_jmp    = bus.opcode == OP_JMP;
  assign is_jal    = bus.opcode == OP_JAL;
  assign is_bne    = bus.opcode == OP_BNE;
  assign is_beq    = bus.opcode == OP_BEQ;
  assign is_bgz    = bus.opcode == OP_BGZ;
  assign is_blz    = bus.opcode == OP_BLZ;
  assign is_branch = is_bne || is_beq || is_bgz || is_blz;

  logic               i_read_c, ir_write_c, d_read_c, d_write_c;
  logic               pc_write_c, pc_write_cond_c, reg_write_c, alu_src_b_c;
  logic               open_port_c, is_halted_c;
  logic [1:0]         pc_src_c, reg_dst_c, wb_src_c;
  logic [ALUOP_W-1:0] alu_op_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // Next state and decoded strobes; everything stays quiet while reset is asserted
  always_comb begin
    state_d         = state_q;
    i_read_c        = 1'b0;
    ir_write_c      = 1'b0;
    d_read_c        = 1'b0;
    d_write_c       = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_src_c        = 2'd0;
    reg_write_c     = 1'b0;
    reg_dst_c       = 2'd0;
    wb_src_c        = 2'd0;
    alu_src_b_c     = 1'b0;
    alu_op_c        = '1;
    open_port_c     = 1'b0;
    is_halted_c     = 1'b0;
    if (reset_n) begin
      case (state_q)
        S_IF: begin
          i_read_c = 1'b1;
          if (bus.i_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
            state_d    = S_ID;
          end
        end
        S_ID: begin
          state_d = S_IF;
          if (is_jmp || is_jal) begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd2;
          end else if (is_jpr || is_jrl) begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'd3;
          end else if (is_hlt) begin
            state_d = S_HALT;
          end else if (is_r_alu || is_wwd || is_branch || is_adi || is_ori ||
                       is_lhi || is_lwd || is_swd) begin
            state_d = S_EX;
          end
          // Link write of PC+1 into $2
          if (is_jal || is_jrl) begin
            reg_write_c = 1'b1;
            reg_dst_c   = 2'd2;
            wb_src_c    = 2'd2;
          end
        end
        S_EX: begin
          state_d = S_IF;
          if (is_branch) begin
            pc_write_cond_c = 1'b1;
            pc_src_c        = 2'd1;
            alu_src_b_c     = is_bgz || is_blz;
            alu_op_c        = is_bne ? ALUOP_W'(9)  :
                              is_beq ? ALUOP_W'(10) :
                              is_bgz ? ALUOP_W'(11) : ALUOP_W'(12);
          end else if (is_wwd) begin
            open_port_c = 1'b1;
          end else if (is_lwd || is_swd) begin
            alu_src_b_c = 1'b1;
            alu_op_c    = ALUOP_W'(0);
            state_d     = S_MEM;
          end else if (is_r_alu) begin
            alu_op_c = ALUOP_W'(bus.func[2:0]);
            state_d  = S_WB;
          end else if (is_adi || is_ori || is_lhi) begin
            alu_src_b_c = 1'b1;
            alu_op_c    = is_adi ? ALUOP_W'(0) : is_ori ? ALUOP_W'(3) : ALUOP_W'(8);
            state_d     = S_WB;
          end
        end
        S_MEM: begin
          d_read_c  = is_lwd;
          d_write_c = !is_lwd;
          if (bus.d_ready) state_d = is_lwd ? S_WB : S_IF;
        end
        S_WB: begin
          reg_write_c = 1'b1;
          reg_dst_c   = is_r ? 2'd1 : 2'd0;
          wb_src_c    = is_lwd ? 2'd1 : 2'd0;
          state_d     = S_IF;
        end
        S_HALT: begin
          is_halted_c = 1'b1;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  assign bus.i_read        = i_read_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.d_read        = d_read_c;
  assign bus.d_write       = d_write_c;
  assign bus.pc_write      = pc_write_c;
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.pc_src        = pc_src_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.wb_src        = wb_src_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.open_port     = open_port_c;
  assign bus.is_halted     = is_halted_c;

`ifdef MULTICYCLE_CTRL_NUM_INST_EN
  logic             retire_c;
  logic [CNT_W-1:0] num_inst_q, num_inst_d;

  // An instruction retires on the edge that returns the FSM to IF or enters HALT
  assign retire_c = (state_q != S_IF) && (state_q != S_HALT) &&
                    ((state_d == S_IF) || (state_d == S_HALT));

  always_comb begin
    num_inst_d = num_inst_q;
    if (retire_c) num_inst_d = num_inst_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) num_inst_q <= '0;
    else          num_inst_q <= num_inst_d;
  end

  assign bus.num_inst = num_inst_q;
`else
  assign bus.num_inst = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle strobe words against hand-derived values,
// plus num_inst on a 16-bit and a 2-bit counter instance.
module tb_multicycle_control;
  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic [5:0] func;
  logic       i_ready;
  logic       d_ready;

  int n_checks;
  int n_fail;
  int exp_cnt;

  multicycle_control_if #(.ALUOP_W(4), .CNT_W(16)) bus1 ();
  multicycle_control_if #(.ALUOP_W(4), .CNT_W(2))  bus2 ();

  assign bus1.opcode  = opcode;
  assign bus1.func    = func;
  assign bus1.i_ready = i_ready;
  assign bus1.d_ready = d_ready;
  assign bus2.opcode  = opcode;
  assign bus2.func    = func;
  assign bus2.i_ready = i_ready;
  assign bus2.d_ready = d_ready;

  multicycle_control #(.ALUOP_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(rst_n), .bus(bus1)
  );
  multicycle_control #(.ALUOP_W(4), .CNT_W(2)) dut_w2 (
    .clk(clk), .reset_n(rst_n), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe word layout:
  // [19] i_read [18] ir_write [17] d_read [16] d_write [15] pc_write [14] pc_write_cond
  // [13:12] pc_src [11] reg_write [10:9] reg_dst [8:7] wb_src [6] alu_src_b
  // [5:2] alu_op [1] open_port [0] is_halted
  localparam logic [19:0] B_IREAD = 20'h80000;
  localparam logic [19:0] B_IRW   = 20'h40000;
  localparam logic [19:0] B_DRD   = 20'h20000;
  localparam logic [19:0] B_DWR   = 20'h10000;
  localparam logic [19:0] B_PCW   = 20'h08000;
  localparam logic [19:0] B_PCWC  = 20'h04000;
  localparam logic [19:0] B_REGW  = 20'h00800;
  localparam logic [19:0] B_SRCB  = 20'h00040;
  localparam logic [19:0] B_OPEN  = 20'h00002;
  localparam logic [19:0] B_HALT  = 20'h00001;

  localparam logic [3:0] OP_BEQ = 4'd1, OP_BGZ = 4'd2, OP_ADI = 4'd4, OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6, OP_LWD = 4'd7, OP_SWD = 4'd8, OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15, OP_BAD = 4'd12;

  function automatic logic [19:0] ps(input logic [1:0] v); return 20'(v) << 12; endfunction
  function automatic logic [19:0] rd(input logic [1:0] v); return 20'(v) << 9;  endfunction
  function automatic logic [19:0] wb(input logic [1:0] v); return 20'(v) << 7;  endfunction
  function automatic logic [19:0] al(input logic [3:0] v); return 20'(v) << 2;  endfunction

  logic [19:0] idle_w;
  logic [19:0] fetch_w;

  function automatic logic [19:0] obs_word();
    return {bus1.i_read, bus1.ir_write, bus1.d_read, bus1.d_write, bus1.pc_write,
            bus1.pc_write_cond, bus1.pc_src, bus1.reg_write, bus1.reg_dst, bus1.wb_src,
            bus1.alu_src_b, bus1.alu_op, bus1.open_port, bus1.is_halted};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_num(input string tag);
`ifdef MULTICYCLE_CTRL_NUM_INST_EN
    check_eq({tag, "_num16"}, 32'(bus1.num_inst), 32'(exp_cnt));
    check_eq({tag, "_num2"},  32'(bus2.num_inst), 32'(exp_cnt % 4));
`else
    check_eq({tag, "_num16"}, 32'(bus1.num_inst), 32'd0);
    check_eq({tag, "_num2"},  32'(bus2.num_inst), 32'd0);
`endif
  endtask

  // Entered at posedge+1: check the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [19:0] exp);
    #1;
    check_eq(tag, 32'(obs_word()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    idle_w   = al(4'hF);
    fetch_w  = B_IREAD | B_IRW | B_PCW | al(4'hF);
    rst_n    = 1'b0;
    opcode   = 4'd0;
    func     = 6'd0;
    i_ready  = 1'b1;
    d_ready  = 1'b1;
    #3;
    check_eq("reset", 32'(obs_word()), 32'(idle_w));
    chk_num("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADI: IF ID EX WB
    set_instr(OP_ADI, 6'd0);
    cyc("adi_if", fetch_w);
    cyc("adi_id", idle_w);
    cyc("adi_ex", B_SRCB | al(4'd0));
    cyc("adi_wb", B_REGW | idle_w);
    exp_cnt = 1;
    chk_num("adi");

    // Fetch wait, then LWD with three MEM wait cycles
    i_ready = 1'b0;
    cyc("if_wait0", B_IREAD | idle_w);
    cyc("if_wait1", B_IREAD | idle_w);
    i_ready = 1'b1;
    set_instr(OP_LWD, 6'd0);
    cyc("lwd_if", fetch_w);
    cyc("lwd_id", idle_w);
    cyc("lwd_ex", B_SRCB | al(4'd0));
    d_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lwd_mem_wait", B_DRD | idle_w);
    d_ready = 1'b1;
    cyc("lwd_mem_done", B_DRD | idle_w);
    cyc("lwd_wb", B_REGW | wb(2'd1) | idle_w);
    exp_cnt = 2;
    chk_num("lwd");

    // JAL
    set_instr(OP_JAL, 6'd0);
    cyc("jal_if", fetch_w);
    cyc("jal_id", B_PCW | ps(2'd2) | B_REGW | rd(2'd2) | wb(2'd2) | idle_w);
    exp_cnt = 3;
    chk_num("jal");

    // BEQ, BGZ
    set_instr(OP_BEQ, 6'd0);
    cyc("beq_if", fetch_w);
    cyc("beq_id", idle_w);
    cyc("beq_ex", B_PCWC | ps(2'd1) | al(4'd10));
    set_instr(OP_BGZ, 6'd0);
    cyc("bgz_if", fetch_w);
    cyc("bgz_id", idle_w);
    cyc("bgz_ex", B_PCWC | ps(2'd1) | B_SRCB | al(4'd11));
    exp_cnt = 5;
    chk_num("bgz");

    // R-type SUB (func 1)
    set_instr(OP_R, 6'd1);
    cyc("sub_if", fetch_w);
    cyc("sub_id", idle_w);
    cyc("sub_ex", al(4'd1));
    cyc("sub_wb", B_REGW | rd(2'd1) | idle_w);

    // LHI
    set_instr(OP_LHI, 6'd0);
    cyc("lhi_if", fetch_w);
    cyc("lhi_id", idle_w);
    cyc("lhi_ex", B_SRCB | al(4'd8));
    cyc("lhi_wb", B_REGW | idle_w);

    // WWD
    set_instr(OP_R, 6'd28);
    cyc("wwd_if", fetch_w);
    cyc("wwd_id", idle_w);
    cyc("wwd_ex", B_OPEN | idle_w);

    // JRL
    set_instr(OP_R, 6'd26);
    cyc("jrl_if", fetch_w);
    cyc("jrl_id", B_PCW | ps(2'd3) | B_REGW | rd(2'd2) | wb(2'd2) | idle_w);

    // Unrecognised opcode retires as NOP from ID
    set_instr(OP_BAD, 6'd0);
    cyc("nop_if", fetch_w);
    cyc("nop_id", idle_w);
    exp_cnt = 10;
    chk_num("nop");

    // SWD stalled in MEM, then reset pulse mid-wait
    set_instr(OP_SWD, 6'd0);
    cyc("swd_if", fetch_w);
    cyc("swd_id", idle_w);
    cyc("swd_ex", B_SRCB | al(4'd0));
    d_ready = 1'b0;
    cyc("swd_mem0", B_DWR | idle_w);
    #1;
    check_eq("swd_mem1", 32'(obs_word()), 32'(B_DWR | idle_w));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("swd_rst", 32'(obs_word()), 32'(idle_w));
    exp_cnt = 0;
    chk_num("swd_rst");
    @(posedge clk);
    #1;
    check_eq("swd_rst_hold", 32'(obs_word()), 32'(idle_w));
    rst_n   = 1'b1;
    d_ready = 1'b1;
    i_ready = 1'b0;
    cyc("swd_release", B_IREAD | idle_w);
    i_ready = 1'b1;

    // ORI then HLT
    set_instr(OP_ORI, 6'd0);
    cyc("ori_if", fetch_w);
    cyc("ori_id", idle_w);
    cyc("ori_ex", B_SRCB | al(4'd3));
    cyc("ori_wb", B_REGW | idle_w);
    set_instr(OP_R, 6'd29);
    cyc("hlt_if", fetch_w);
    cyc("hlt_id", idle_w);
    exp_cnt = 2;
    for (int i = 0; i < 4; i++) begin
      cyc("halt", B_HALT | idle_w);
      chk_num("halt");
    end

    // Only reset leaves HALT
    rst_n = 1'b0;
    #1;
    check_eq("halt_rst", 32'(obs_word()), 32'(idle_w));
    exp_cnt = 0;
    chk_num("halt_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("halt_release", fetch_w);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALUOP_W, default 4: width of alu_op; SHALL be at least 4.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter num_inst.
REQ-003 clk  input  1  single clock; all state changes SHALL occur on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 opcode  input  4  instruction-register opcode field; encodings per the shared opcodes header.
REQ-006 func  input  6  instruction-register function field.
REQ-007 i_ready  input  1  instruction memory has returned the fetched word this cycle.
REQ-008 d_ready  input  1  data memory has completed the access this cycle.
REQ-009 i_read / ir_write  output  1 each  fetch request; instruction-register load strobe.
REQ-010 d_read / d_write  output  1 each  data-memory read / write request.
REQ-011 pc_write / pc_write_cond  output  1 each  unconditional PC load; PC load gated by ALU branch result.
REQ-012 pc_src  output  2  0 = PC+1, 1 = branch target, 2 = jump target, 3 = register (JPR/JRL).
REQ-013 reg_write  output  1  register-file write strobe.
REQ-014 reg_dst  output  2  0 = rt, 1 = rd, 2 = link register $2.
REQ-015 wb_src  output  2  0 = ALU result, 1 = memory data, 2 = PC+1 (link).
REQ-016 alu_src_b  output  1  0 = register rt, 1 = sign-extended immediate.
REQ-017 alu_op  output  ALUOP_W  ALU operation code.
REQ-018 open_port  output  1  output-port enable for WWD.
REQ-019 is_halted  output  1  CPU has executed HLT.
REQ-020 num_inst  output  CNT_W  retired-instruction count.

Function
REQ-021 The FSM SHALL have the states IF, ID, EX, MEM, WB and HALT; all outputs SHALL be Moore or state-plus-opcode decoded; no output SHALL depend combinationally on i_ready or d_ready except ir_write and pc_write in IF.
REQ-022 IF: i_read=1; the FSM SHALL stay in IF while i_ready=0; in the cycle i_ready=1 it SHALL assert ir_write and pc_write with pc_src=0, then go to ID.
REQ-023 ID, JMP: pc_write=1, pc_src=2, then IF. JAL: the same plus reg_write=1, reg_dst=2, wb_src=2. JPR: pc_write=1, pc_src=3, then IF. JRL: JPR plus the JAL link write. HLT: go to HALT. Unrecognised opcode/func: go to IF with no strobes (NOP). All other instructions go to EX.
REQ-024 EX, BNE/BEQ/BGZ/BLZ: pc_write_cond=1, pc_src=1, then IF. WWD: open_port=1, then IF. LWD/SWD: alu_src_b=1, then MEM. R-type ALU/ADI/ORI/LHI: then WB.
REQ-025 alu_op in EX: R-type with func<8 gives func zero-extended; ADI/LWD/SWD give 0; ORI 3; LHI 8; BNE 9; BEQ 10; BGZ 11; BLZ 12. In every other state/instruction alu_op SHALL be all ones.
REQ-026 alu_src_b SHALL be 1 in EX for ADI/ORI/LHI/LWD/SWD/BGZ/BLZ and 0 otherwise.
REQ-027 MEM: d_read=1 (LWD) or d_write=1 (SWD); the FSM SHALL hold while d_ready=0. On d_ready=1, LWD goes to WB and SWD goes to IF.
REQ-028 WB: reg_write=1; reg_dst=1 for R-type, else 0; wb_src=1 for LWD, else 0; then IF.
REQ-029 Retirement is the final cycle of each instruction (the transition into IF or HALT, including NOP). num_inst SHALL increment by 1 on that edge and wrap modulo 2^CNT_W.
REQ-030 Minimum latency in cycles, zero wait states: jump 2, branch/WWD 3, ALU/SWD 4, LWD 5.
REQ-031 HALT: is_halted=1 and all strobes 0; HALT SHALL be left only by reset; HLT SHALL be counted once.

Reset
REQ-032 reset_n=0 SHALL immediately force state IF, num_inst=0, is_halted=0 and every strobe to 0, from any state including mid-wait in IF or MEM.
REQ-033 In the first cycle after reset_n rises, i_read SHALL be 1.

Configuration
REQ-034 With macro MULTICYCLE_CTRL_NUM_INST_EN defined, num_inst SHALL behave per REQ-029; without it, num_inst SHALL be tied to 0 and no counter register SHALL be synthesised.

Verification
REQ-035 ADI with i_ready=1 and d_ready=1 held: IF->ID->EX->WB->IF; alu_op=0 and alu_src_b=1 in EX; reg_write=1 in WB; num_inst goes 0->1.
REQ-036 LWD with d_ready low for 3 MEM cycles: MEM lasts 4 cycles with d_read=1 throughout; then WB with wb_src=1; total 8 cycles.
REQ-037 JAL: exactly 2 cycles; in ID pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wb_src=2.
REQ-038 reset_n pulsed low during the MEM wait of SWD: d_write drops in the same cycle, state is IF, num_inst=0, and i_read=1 after release.
REQ-039 HLT: is_halted=1 forever and num_inst increments exactly once; with CNT_W=2, five retirements give num_inst=1.
